// File: rtl/decoder_al.sv
// decoder_al: registered 2-to-4 one-hot decoder with enable.
// Output polarity selectable; synchronous active-high reset.
module decoder_al #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic sel2,
  input  logic en,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  // Output value used for reset and for the disabled state.
  localparam logic [3:0] IDLE = {4{OUT_ACTIVE_LOW}};

  logic [1:0] idx;
  logic [3:0] hot;
  logic [3:0] q;

  assign idx = {sel2, sel};

  // Active-high one-hot decode of the select index, gated by en.
  always_comb begin
    hot = 4'b0000;
    if (en) begin
      unique case (idx)
        2'd0:    hot = 4'b0001;
        2'd1:    hot = 4'b0010;
        2'd2:    hot = 4'b0100;
        2'd3:    hot = 4'b1000;
        default: hot = 4'b0000;
      endcase
    end
  end

  // Output flops; polarity applied before the register so
  // the outputs are glitch-free flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= IDLE;
    end else begin
      q <= hot ^ IDLE;
    end
  end

  assign a = q[0];
  assign b = q[1];
  assign c = q[2];
  assign d = q[3];

endmodule

// File: tb/tb_decoder_al.sv
// tb_decoder_al: directed and randomized checks of decoder_al,
// both output polarities, against a behavioural model.
module tb_decoder_al;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic sel2 = 1'b0;
  logic en = 1'b0;
  logic ha, hb, hc, hd;
  logic la, lb, lc, ld;

  int checks = 0;
  int failures = 0;

  logic [3:0] prev_exp;
  bit prev_valid = 1'b0;

  always #5 clk = ~clk;

  decoder_al #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .sel(sel), .sel2(sel2), .en(en),
    .a(ha), .b(hb), .c(hc), .d(hd)
  );

  decoder_al #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .sel(sel), .sel2(sel2), .en(en),
    .a(la), .b(lb), .c(lc), .d(ld)
  );

  // Reference: abcd as a nibble, a in the MSB.
  function automatic logic [3:0] model(
    input logic r, input logic e, input logic s2, input logic s
  );
    int ix;
    ix = {s2, s};
    if (r) return 4'b0000;
    if (!e) return 4'b0000;
    return 4'b1000 >> ix;
  endfunction

  task automatic check(input string tag, input logic [3:0] exp_hi);
    logic [3:0] oh, ol;
    oh = {ha, hb, hc, hd};
    ol = {la, lb, lc, ld};
    checks++;
    assert (oh === exp_hi) else begin
      failures++;
      $error("FAIL %s hi: got %b want %b", tag, oh, exp_hi);
    end
    checks++;
    assert (ol === ~exp_hi) else begin
      failures++;
      $error("FAIL %s lo: got %b want %b", tag, ol, ~exp_hi);
    end
  endtask

  // Drive inputs mid-cycle, confirm outputs hold until the edge,
  // then check the registered decode just after the edge.
  task automatic step(
    input string tag, input logic r, input logic e,
    input logic s2, input logic s, input logic [3:0] want
  );
    logic [3:0] m;
    rst = r; en = e; sel2 = s2; sel = s;
    #2;
    if (prev_valid) check({tag, "_hold"}, prev_exp);
    m = model(r, e, s2, s);
    checks++;
    assert (m === want) else begin
      failures++;
      $error("FAIL %s model: got %b want %b", tag, m, want);
    end
    @(posedge clk);
    #1;
    check(tag, m);
    prev_exp = m;
    prev_valid = 1'b1;
  endtask

  initial begin
    // Reset held two cycles with en=1, index 3.
    step("rst0", 1, 1, 1, 1, 4'b0000);
    step("rst1", 1, 1, 1, 1, 4'b0000);
    step("rel", 0, 1, 1, 1, 4'b0001);
    // Full sweep.
    step("sw0", 0, 1, 0, 0, 4'b1000);
    step("sw1", 0, 1, 0, 1, 4'b0100);
    step("sw2", 0, 1, 1, 0, 4'b0010);
    step("sw3", 0, 1, 1, 1, 4'b0001);
    // Enable gating.
    step("dis0", 0, 0, 0, 0, 4'b0000);
    step("dis1", 0, 0, 0, 1, 4'b0000);
    step("dis2", 0, 0, 1, 0, 4'b0000);
    step("dis3", 0, 0, 1, 1, 4'b0000);
    step("en2", 0, 1, 1, 0, 4'b0010);
    // Mid-operation reset.
    step("mid", 1, 1, 1, 0, 4'b0000);
    step("back", 0, 1, 1, 0, 4'b0010);
    // Same-cycle change of en and selects.
    step("i1", 0, 1, 0, 1, 4'b0100);
    step("chg", 0, 0, 1, 1, 4'b0000);
    step("i3", 0, 1, 1, 1, 4'b0001);
    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic r, e, s2, s;
      r = ($urandom_range(0, 15) == 0);
      e = $urandom_range(0, 3) != 0;
      s2 = 1'($urandom);
      s = 1'($urandom);
      step("rnd", r, e, s2, s, model(r, e, s2, s));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
